// File: rtl/fwft_nibble_packer.sv
// ---------------------------------------------------------------------------
// fwft_nibble_packer
//
// This block reads a first-word-fall-through FIFO. It packs RATIO consecutive
// IN_WIDTH-bit entries into one OUT_WIDTH-bit word. The word is then offered
// on a registered valid/ready stream. The first entry popped lands in the
// least-significant slot.
//
// When the downstream side stalls, the block stops reading the FIFO. It never
// drops or duplicates an entry.
//
// Optional feature macro: FWFT_NIBBLE_PACKER_FLUSH_EN
//   defined   : adds the flush input and a pending-flush register. A flush
//               emits the partially filled accumulator as a zero-padded word
//               with m_partial=1.
//   undefined : there is no flush port and m_partial is tied to 0.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   fifo_dout   FWFT head entry, valid while fifo_empty=0
//   fifo_empty  FIFO empty flag
//   fifo_rd_en  pop strobe (combinational), consumes the head this cycle
//   m_data      packed output word
//   m_valid     m_data holds a word
//   m_ready     downstream accepts when m_valid & m_ready
//   m_partial   word was zero-padded by a flush
//   flush       single-cycle partial-word request (flush build only)
// ---------------------------------------------------------------------------
//
// Fill state machine (cnt, plus flush_pend in the flush build)
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   FILL_0     | accumulator empty, the next pop goes to slot 0
//   FILL_k     | k entries held; a pop in FILL_(RATIO-1) completes a word
//   FLUSH_PEND | partial word waiting for the output register to free up
// ---------------------------------------------------------------------------
module fwft_nibble_packer #(
    parameter int IN_WIDTH  = 4,
    parameter int RATIO     = 4,
    parameter int OUT_WIDTH = IN_WIDTH * RATIO
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IN_WIDTH-1:0]  fifo_dout,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    output logic [OUT_WIDTH-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_partial
`ifdef FWFT_NIBBLE_PACKER_FLUSH_EN
    ,
    input  logic                 flush
`endif
);

    localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    // The last entry of a word goes straight into m_data, so the
    // accumulator only needs RATIO-1 slots.
    localparam int ACC_W = (RATIO - 1) * IN_WIDTH;
    localparam logic [CW-1:0] CNT_LAST = CW'(RATIO - 1);

    logic [CW-1:0]        cnt, cnt_nxt;
    logic [ACC_W-1:0]     acc, acc_nxt;
    logic [OUT_WIDTH-1:0] data_nxt;
    logic                 valid_nxt;
    logic                 out_free;
    logic                 at_last;
    logic                 pop;
    logic                 pend;

`ifdef FWFT_NIBBLE_PACKER_FLUSH_EN
    logic flush_pend, pend_nxt;
    logic partial_q, partial_nxt;

    assign pend      = flush_pend;
    assign m_partial = partial_q;
`else
    assign pend      = 1'b0;
    assign m_partial = 1'b0;
`endif

    // A pop is allowed when there is room in the accumulator. A pop that
    // completes a word also needs the output register to be free. Pops are
    // gated with rst_n so nothing is consumed while the block is in reset.
    always_comb begin
        out_free = !m_valid || m_ready;
        at_last  = (cnt == CNT_LAST);
        pop      = rst_n && !fifo_empty && !pend && (!at_last || out_free);
    end

    assign fifo_rd_en = pop;

    always_comb begin
        cnt_nxt   = cnt;
        acc_nxt   = acc;
        data_nxt  = m_data;
        valid_nxt = m_valid;
`ifdef FWFT_NIBBLE_PACKER_FLUSH_EN
        pend_nxt    = flush_pend;
        partial_nxt = partial_q;
`endif

        if (m_valid && m_ready) begin
            valid_nxt = 1'b0;
        end

`ifdef FWFT_NIBBLE_PACKER_FLUSH_EN
        // A pending flush blocks pops, so this branch and the pop branch
        // below are never active in the same cycle.
        if (flush_pend && out_free) begin
            data_nxt    = {{IN_WIDTH{1'b0}}, acc};
            valid_nxt   = 1'b1;
            partial_nxt = 1'b1;
            cnt_nxt     = '0;
            acc_nxt     = '0;
            pend_nxt    = 1'b0;
        end
`endif

        if (pop) begin
            if (at_last) begin
                data_nxt  = {fifo_dout, acc};
                valid_nxt = 1'b1;
`ifdef FWFT_NIBBLE_PACKER_FLUSH_EN
                partial_nxt = 1'b0;
`endif
                cnt_nxt   = '0;
                acc_nxt   = '0;
            end else begin
                for (int i = 0; i < RATIO - 1; i++) begin
                    if (cnt == CW'(i)) begin
                        acc_nxt[i*IN_WIDTH +: IN_WIDTH] = fifo_dout;
                    end
                end
                cnt_nxt = cnt + CW'(1);
            end
        end

`ifdef FWFT_NIBBLE_PACKER_FLUSH_EN
        // The flush test uses the count after this cycle's pop. As a result,
        // a pop that completes a word swallows the flush, and so does a flush
        // on an empty accumulator.
        if (flush && (cnt_nxt != '0)) begin
            pend_nxt = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            acc     <= '0;
            m_data  <= '0;
            m_valid <= 1'b0;
`ifdef FWFT_NIBBLE_PACKER_FLUSH_EN
            flush_pend <= 1'b0;
            partial_q  <= 1'b0;
`endif
        end else begin
            cnt     <= cnt_nxt;
            acc     <= acc_nxt;
            m_data  <= data_nxt;
            m_valid <= valid_nxt;
`ifdef FWFT_NIBBLE_PACKER_FLUSH_EN
            flush_pend <= pend_nxt;
            partial_q  <= partial_nxt;
`endif
        end
    end

endmodule
